regfile_wb_queue: RTL and testbench
===================================

// Module: regfile_wb_queue
// PURPOSE
//   Write-side feeder for the register file: buffers result writes (id, value) from execution units
//   in an in-order FIFO and drains one entry per cycle into the register file's single write port.
//   Drives the write port encoding: w1[M] = 1 means no write.
//   Gives two read-side bypass lookups, so readers see values that are queued but not yet committed.
// PARAMETERS
//   N      32  data width of register values
//   M      2   register id width (2^M registers)
//   DEPTH  4   queue entries; power of 2, >= 2
// PORTS
//   clk       in   1          clock, all state updates on posedge
//   rst_n     in   1          asynchronous reset, active-low
//   in_valid  in   1          producer presents a write request
//   in_ready  out  1          queue can accept; a push happens when in_valid && in_ready
//   in_id     in   M          destination register id
//   in_val    in   N          value to write
//   rf_stall  in   1          1 = do not drain this cycle
//   rf_w1     out  M+1        register-file write id; MSB = 1 means disabled; registered
//   rf_w      out  N          register-file write value; registered
//   q1_id     in   M          bypass lookup 1 id
//   q1_hit    out  1          a pending write to q1_id exists
//   q1_val    out  N          newest pending value for q1_id; 0 if no hit
//   q2_id     in   M          bypass lookup 2 id (same rules as lookup 1)
//   q2_hit    out  1          see q1_hit
//   q2_val    out  N          see q1_val
//   count     out  $clog2(DEPTH)+1  number of valid entries
//   empty     out  1          count == 0
//   full      out  1          count == DEPTH
// BEHAVIOUR
//   Reset (async, rst_n = 0): pointers = 0, count = 0, rf_w1 = {1'b1, M'b0}, rf_w = 0.
//     All queued entries are dropped. Reset mid-drain cancels the write held in rf_w1/rf_w.
//   in_ready = !full; this is combinational and does not depend on a same-cycle pop.
//   Drain: at a posedge with !empty && !rf_stall:
//     - pop the head;
//     - rf_w1 <= {1'b0, head.id}, rf_w <= head.val.
//     Otherwise rf_w1 <= {1'b1, M'b0} and rf_w holds its value.
//   The register file commits at the following posedge, so a write is visible in the register file
//     2 cycles after the posedge where it was pushed, or later if the queue is not empty.
//   Push and pop in the same cycle: both happen; count is unchanged; pointers wrap modulo DEPTH.
//   Order: entries drain strictly FIFO. Two writes to the same id commit in push order.
//   Bypass (combinational):
//     - search the rf_w1/rf_w output register and all valid queue entries for a matching id;
//     - the newest match wins, with priority queue tail > ... > head > output register;
//     - the output register counts only when rf_w1[M] == 0;
//     - a same-cycle push (in_valid && in_ready) is not searched.
//   count and empty/full: registered count with combinational decode. count never exceeds DEPTH.
// CONFIGURATION
//   WBQ_COALESCE_EN defined:
//     - a push whose in_id matches a valid entry overwrites that entry's value in place;
//       count is unchanged and the entry keeps its FIFO position.
//     - at most one entry per id is therefore ever queued.
//     - if the matching entry is the head being popped this same cycle, the push appends normally.
//     - when full, a push that would coalesce is still blocked because in_ready = !full.
//   Not defined: every accepted push appends a new entry, and duplicate ids may coexist.
// TESTING
//   1. Reset, then push (id 2, 0xAAAA) with rf_stall = 0 -> next cycle rf_w1 = 3'b010, rf_w = 0xAAAA;
//      cycle after, rf_w1 = 3'b100; empty = 1.
//   2. rf_stall = 1, push ids 0,1,2,3 with values 0x10..0x13 -> full = 1, in_ready = 0, count = 4;
//      release the stall -> rf_w1 shows 0,1,2,3 on 4 consecutive cycles.
//   3. Stalled, push (1, 0x5) then (1, 0x6); q1_id = 1 -> q1_hit = 1, q1_val = 0x6
//      (coalesce build: count = 1, otherwise count = 2); q2_id = 3 -> q2_hit = 0, q2_val = 0.
//   4. Count = 2 with continuous push and pop for 8 cycles -> count stays 2;
//      drain order matches push order across pointer wrap.
//   5. Pull rst_n low while 3 entries are queued and rf_w1 = 3'b001 -> immediately rf_w1 = 3'b100,
//      count = 0; no further writes after release.
//   6. Value sits only in the output register (queue empty, rf_w1 = 3'b011, rf_w = 0x77); q2_id = 3
//      -> q2_hit = 1, q2_val = 0x77.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   In-order write-back queue that feeds the register file's single write port.
//   Result writes (id, value) are buffered and drained one per cycle unless stalled.
//   The registered write port uses rf_w1[M] = 1 to mean "no write this cycle".
//   Two combinational bypass lookups expose the newest pending value for an id,
//   searching the queue (tail first) and then the write-port output register.
//   Optional build macro: WBQ_COALESCE_EN
//     When defined, a push to an id that is already queued overwrites that entry's
//     value in place instead of appending. A match on the head entry that is being
//     popped this same cycle does not coalesce; the push appends instead.
module regfile_wb_queue #(
  parameter int N     = 32,
  parameter int M     = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [M-1:0]            in_id,
  input  logic [N-1:0]            in_val,
  input  logic                    rf_stall,
  output logic [M:0]              rf_w1,
  output logic [N-1:0]            rf_w,
  input  logic [M-1:0]            q1_id,
  output logic                    q1_hit,
  output logic [N-1:0]            q1_val,
  input  logic [M-1:0]            q2_id,
  output logic                    q2_hit,
  output logic [N-1:0]            q2_val,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue storage and pointers
  logic [M-1:0]     id_mem_r  [DEPTH];
  logic [N-1:0]     val_mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;

  // Write-port output register
  logic [M:0]       rf_w1_r;
  logic [N-1:0]     rf_w_r;

  // Per-cycle control
  logic [DEPTH-1:0] slot_valid_s;
  logic [DEPTH-1:0] match_s;
  logic             push_s;
  logic             pop_s;
  logic             merge_s;
  logic             append_s;
  logic [PW-1:0]    merge_idx_s;
  logic             full_s;
  logic             empty_s;

  assign full_s   = (count_r == CW'(DEPTH));
  assign empty_s  = (count_r == {CW{1'b0}});
  assign in_ready = !full_s;
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;
  assign rf_w1    = rf_w1_r;
  assign rf_w     = rf_w_r;

  assign push_s   = in_valid && !full_s;
  assign pop_s    = !empty_s && !rf_stall;

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_valid_s[gi] = ({1'b0, PW'(gi) - rd_ptr_r} < count_r);
`ifdef WBQ_COALESCE_EN
    // The head leaving this cycle cannot absorb a push; the push appends behind it.
    assign match_s[gi] = slot_valid_s[gi] && (id_mem_r[gi] == in_id) &&
                         !(pop_s && (PW'(gi) == rd_ptr_r));
`else
    assign match_s[gi] = 1'b0;
`endif
  end

  // Pick the slot a coalescing push overwrites; at most one live entry per id exists.
  always_comb begin
    merge_idx_s = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      merge_idx_s = match_s[i] ? PW'(i) : merge_idx_s;
    end
    merge_s  = push_s && (|match_s);
    append_s = push_s && !merge_s;
  end

  // Newest pending value for qid: output register first, then head..tail so the tail wins.
  function automatic logic [N:0] bypass_lookup(input logic [M-1:0] qid);
    logic [N:0]    res;
    logic [PW-1:0] idx;
    res = (!rf_w1_r[M] && (rf_w1_r[M-1:0] == qid)) ? {1'b1, rf_w_r} : {(N+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_r + PW'(k);
      res = (slot_valid_s[idx] && (id_mem_r[idx] == qid)) ? {1'b1, val_mem_r[idx]} : res;
    end
    return res;
  endfunction

  // Both bypass ports share the same search; a same-cycle push is not yet visible.
  always_comb begin
    {q1_hit, q1_val} = bypass_lookup(q1_id);
    {q2_hit, q2_val} = bypass_lookup(q2_id);
  end

  // Entry storage: append at the tail or overwrite the value of a coalesced entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_mem_r[i]  <= {M{1'b0}};
        val_mem_r[i] <= {N{1'b0}};
      end
    end else if (append_s) begin
      id_mem_r[wr_ptr_r]  <= in_id;
      val_mem_r[wr_ptr_r] <= in_val;
    end else if (merge_s) begin
      val_mem_r[merge_idx_s] <= in_val;
    end
  end

  // Pointers and occupancy; a simultaneous append and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (append_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      count_r <= count_r + CW'(append_s) - CW'(pop_s);
    end
  end

  // Write port: load the popped head, otherwise disable the write and hold the value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_w1_r <= {1'b1, {M{1'b0}}};
      rf_w_r  <= {N{1'b0}};
    end else if (pop_s) begin
      rf_w1_r <= {1'b0, id_mem_r[rd_ptr_r]};
      rf_w_r  <= val_mem_r[rd_ptr_r];
    end else begin
      rf_w1_r <= {1'b1, {M{1'b0}}};
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed scenarios plus randomized traffic,
// checked against a queue-based reference model. Works with or without WBQ_COALESCE_EN.
module tb_regfile_wb_queue;

  localparam int N     = 32;
  localparam int M     = 2;
  localparam int DEPTH = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [M-1:0]  in_id    = 2'd0;
  logic [N-1:0]  in_val   = 32'd0;
  logic          rf_stall = 1'b0;
  logic [M:0]    rf_w1;
  logic [N-1:0]  rf_w;
  logic [M-1:0]  q1_id    = 2'd0;
  logic          q1_hit;
  logic [N-1:0]  q1_val;
  logic [M-1:0]  q2_id    = 2'd0;
  logic          q2_hit;
  logic [N-1:0]  q2_val;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_queue #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_val(in_val),
    .rf_stall(rf_stall), .rf_w1(rf_w1), .rf_w(rf_w),
    .q1_id(q1_id), .q1_hit(q1_hit), .q1_val(q1_val),
    .q2_id(q2_id), .q2_hit(q2_hit), .q2_val(q2_val),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed { logic [1:0] id; logic [31:0] val; } ent_t;
  ent_t        mq[$];
  bit          out_en  = 1'b0;
  logic [1:0]  out_id  = 2'd0;
  logic [31:0] out_val = 32'd0;

  function automatic void model_reset();
    mq.delete();
    out_en  = 1'b0;
    out_id  = 2'd0;
    out_val = 32'd0;
  endfunction

  // One clock edge worth of queue behaviour, using the inputs currently applied.
  function automatic void model_update();
    bit   do_pop;
    bit   do_push;
    int   hit_idx;
    ent_t e;
    do_pop  = (mq.size() > 0) && !rf_stall;
    do_push = in_valid && (mq.size() < DEPTH);
    hit_idx = -1;
`ifdef WBQ_COALESCE_EN
    if (do_push)
      for (int j = 0; j < mq.size(); j++)
        if (mq[j].id == in_id && !(do_pop && j == 0)) hit_idx = j;
`endif
    if (hit_idx >= 0) begin
      e = mq[hit_idx];
      e.val = in_val;
      mq[hit_idx] = e;
    end
    if (do_pop) begin
      e = mq.pop_front();
      out_en  = 1'b1;
      out_id  = e.id;
      out_val = e.val;
    end else begin
      out_en = 1'b0;
    end
    if (do_push && hit_idx < 0) begin
      e.id  = in_id;
      e.val = in_val;
      mq.push_back(e);
    end
  endfunction

  // Newest pending value: output register is oldest, the queue back is newest.
  function automatic void model_lookup(input logic [1:0] qid, output bit hit, output logic [31:0] v);
    hit = 1'b0;
    v   = 32'd0;
    if (out_en && out_id == qid) begin hit = 1'b1; v = out_val; end
    for (int j = 0; j < mq.size(); j++)
      if (mq[j].id == qid) begin hit = 1'b1; v = mq[j].val; end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [1:0] id, input logic [31:0] val,
                       input bit st, input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    in_valid = v; in_id = id; in_val = val; rf_stall = st; q1_id = a; q2_id = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    model_reset();
    n_checks++; if (rf_w1 !== 3'b100) begin n_fail++; $display("FAIL reset_rf_w1 got=%b exp=100", rf_w1); end
    n_checks++; if (rf_w !== 32'd0) begin n_fail++; $display("FAIL reset_rf_w got=%h exp=0", rf_w); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_flags got empty=%b full=%b rdy=%b exp 1 0 1", empty, full, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    drive(1'b1, 2'd2, 32'hAAAA, 1'b0, 2'd2, 2'd1); tick();
    drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd2, 2'd1);
    n_checks++; if (q1_hit !== 1'b1 || q1_val !== 32'hAAAA) begin
      n_fail++; $display("FAIL single_bypass_q got hit=%b val=%h exp 1 aaaa", q1_hit, q1_val); end
    n_checks++; if (rf_w1 !== 3'b100) begin n_fail++; $display("FAIL single_idle got=%b exp=100", rf_w1); end
    tick();
    drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd2, 2'd1);
    n_checks++; if (rf_w1 !== 3'b010 || rf_w !== 32'hAAAA) begin
      n_fail++; $display("FAIL single_write got w1=%b w=%h exp 010 aaaa", rf_w1, rf_w); end
    n_checks++; if (q1_hit !== 1'b1 || q1_val !== 32'hAAAA || q2_hit !== 1'b0) begin
      n_fail++; $display("FAIL single_bypass_out got hit=%b val=%h q2hit=%b exp 1 aaaa 0", q1_hit, q1_val, q2_hit); end
    tick();
    drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd2, 2'd1);
    n_checks++; if (rf_w1 !== 3'b100 || empty !== 1'b1 || q1_hit !== 1'b0) begin
      n_fail++; $display("FAIL single_done got w1=%b empty=%b hit=%b exp 100 1 0", rf_w1, empty, q1_hit); end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 32'h10 + 32'(k), 1'b1, 2'd0, 2'd0); tick();
    end
    drive(1'b1, 2'd0, 32'h99, 1'b1, 2'd0, 2'd0);
    n_checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
      n_fail++; $display("FAIL fill_full got full=%b rdy=%b cnt=%0d exp 1 0 4", full, in_ready, count); end
    tick();
    drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_blocked got=%0d exp=4", count); end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0);
      n_checks++; if (rf_w1 !== {1'b0, 2'(k)} || rf_w !== 32'h10 + 32'(k)) begin
        n_fail++; $display("FAIL drain_order k=%0d got w1=%b w=%h exp id %0d val %h", k, rf_w1, rf_w, k, 32'h10 + 32'(k)); end
      tick();
    end
    drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0);
    n_checks++; if (rf_w1 !== 3'b100 || empty !== 1'b1) begin
      n_fail++; $display("FAIL drain_end got w1=%b empty=%b exp 100 1", rf_w1, empty); end
  endtask

  task automatic test_bypass_dup();
    logic [2:0] exp_cnt;
`ifdef WBQ_COALESCE_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    drive(1'b1, 2'd1, 32'h5, 1'b1, 2'd1, 2'd3); tick();
    drive(1'b1, 2'd1, 32'h6, 1'b1, 2'd1, 2'd3); tick();
    drive(1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 2'd3);
    n_checks++; if (q1_hit !== 1'b1 || q1_val !== 32'h6) begin
      n_fail++; $display("FAIL dup_newest got hit=%b val=%h exp 1 6", q1_hit, q1_val); end
    n_checks++; if (count !== exp_cnt) begin n_fail++; $display("FAIL dup_count got=%0d exp=%0d", count, exp_cnt); end
    n_checks++; if (q2_hit !== 1'b0 || q2_val !== 32'd0) begin
      n_fail++; $display("FAIL dup_miss got hit=%b val=%h exp 0 0", q2_hit, q2_val); end
    for (int k = 0; k < 3; k++) begin drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0); tick(); end
  endtask

  task automatic test_outreg_bypass();
    drive(1'b1, 2'd3, 32'h77, 1'b0, 2'd3, 2'd3); tick();
    drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd3, 2'd3); tick();
    drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd3);
    n_checks++; if (empty !== 1'b1 || rf_w1 !== 3'b011 || rf_w !== 32'h77) begin
      n_fail++; $display("FAIL outreg_state got empty=%b w1=%b w=%h exp 1 011 77", empty, rf_w1, rf_w); end
    n_checks++; if (q2_hit !== 1'b1 || q2_val !== 32'h77 || q1_hit !== 1'b0 || q1_val !== 32'd0) begin
      n_fail++; $display("FAIL outreg_hit got q2=%b/%h q1=%b/%h exp 1/77 0/0", q2_hit, q2_val, q1_hit, q1_val); end
    // Queue entry must win over the output register for the same id.
    drive(1'b1, 2'd3, 32'h11, 1'b0, 2'd3, 2'd3); tick();
    drive(1'b1, 2'd3, 32'h22, 1'b0, 2'd3, 2'd3); tick();
    drive(1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 2'd3);
    n_checks++; if (rf_w1 !== 3'b011 || rf_w !== 32'h11 || q2_val !== 32'h22 || count !== 3'd1) begin
      n_fail++; $display("FAIL outreg_prio got w1=%b w=%h q2=%h cnt=%0d exp 011 11 22 1", rf_w1, rf_w, q2_val, count); end
    tick();
    for (int k = 0; k < 2; k++) begin drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0); tick(); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_w1;
    drive(1'b1, 2'd0, 32'h100, 1'b1, 2'd0, 2'd0); tick();
    drive(1'b1, 2'd1, 32'h101, 1'b1, 2'd0, 2'd0); tick();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 2'(c + 2), 32'h102 + 32'(c), 1'b0, 2'd0, 2'd0);
      exp_w1 = out_en ? {1'b0, out_id} : 3'b100;
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count c=%0d got=%0d exp=2", c, count); end
      n_checks++; if (rf_w1 !== exp_w1 || rf_w !== out_val) begin
        n_fail++; $display("FAIL b2b_order c=%0d got w1=%b w=%h exp %b %h", c, rf_w1, rf_w, exp_w1, out_val); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0); tick(); end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k + 1), 32'h200 + 32'(k), 1'b1, 2'd0, 2'd0); tick();
    end
    drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0); tick();
    drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd1, 2'd0);
    n_checks++; if (rf_w1 !== 3'b001 || count !== 3'd3) begin
      n_fail++; $display("FAIL rstmid_pre got w1=%b cnt=%0d exp 001 3", rf_w1, count); end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (rf_w1 !== 3'b100 || count !== 3'd0 || rf_w !== 32'd0 || q1_hit !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_now got w1=%b cnt=%0d w=%h hit=%b exp 100 0 0 0", rf_w1, count, rf_w, q1_hit); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0);
      n_checks++; if (rf_w1 !== 3'b100 || empty !== 1'b1) begin
        n_fail++; $display("FAIL rstmid_after k=%0d got w1=%b empty=%b exp 100 1", k, rf_w1, empty); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [2:0]  exp_w1;
    bit          h1, h2;
    logic [31:0] v1, v2;
    bit          st;
    for (int c = 0; c < 400; c++) begin
      st = (c < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, st,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      exp_w1 = out_en ? {1'b0, out_id} : 3'b100;
      model_lookup(q1_id, h1, v1);
      model_lookup(q2_id, h2, v2);
      n_checks++; if (rf_w1 !== exp_w1) begin n_fail++; $display("FAIL rand_rf_w1 c=%0d got=%b exp=%b", c, rf_w1, exp_w1); end
      n_checks++; if (rf_w !== out_val) begin n_fail++; $display("FAIL rand_rf_w c=%0d got=%h exp=%h", c, rf_w, out_val); end
      n_checks++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
      n_checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) || in_ready !== (mq.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_flags c=%0d got e=%b f=%b r=%b size=%0d", c, empty, full, in_ready, mq.size()); end
      n_checks++; if (q1_hit !== h1 || q1_val !== v1) begin
        n_fail++; $display("FAIL rand_q1 c=%0d got %b/%h exp %b/%h", c, q1_hit, q1_val, h1, v1); end
      n_checks++; if (q2_hit !== h2 || q2_val !== v2) begin
        n_fail++; $display("FAIL rand_q2 c=%0d got %b/%h exp %b/%h", c, q2_hit, q2_val, h2, v2); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_drain();
    test_bypass_dup();
    test_outreg_bypass();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
